neuron_mac_seq: RTL and testbench

- Parametrised, sequential successor to the two-input output neuron.
- Computes y = act(sum over i of a[i]*w[i], plus b) for N_IN inputs in signed fixed-point format Q(WIDTH-FRAC).FRAC.
- Uses one time-multiplexed multiplier, a widened saturating accumulator, optional bypass of the existing combinational tanh unit, and valid/ready handshakes on both sides.
- Sits between the hidden-layer neurons and the network output register stage.

---
 rtl/neuron_mac_seq.sv | 202 ++++++++++++++++++++
 tb/tb_neuron_mac_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_seq.sv
// Sequential output neuron: one shared multiplier accumulates N_IN products plus bias,
// then a single saturation and optional tanh produce a registered, handshaked result.

module neuron_tanh #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y
);
    localparam int LW = WIDTH + 17;
    localparam logic [WIDTH-1:0] HALF = {{(WIDTH-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic [WIDTH-1:0] X_1P0 = HALF << 1;
    localparam logic [WIDTH-1:0] X_1P5 = HALF + (HALF << 1);
    localparam logic [WIDTH-1:0] X_2P0 = HALF << 2;
    localparam logic [WIDTH-1:0] X_3P0 = (HALF << 2) + (HALF << 1);

    // Breakpoint values and slopes are held in Q0.16 and rescaled to FRAC bits.
    function automatic logic [WIDTH-1:0] q16_to_q(input logic [16:0] c);
        logic [LW-1:0] t;
        t = LW'(c) << FRAC;
        return WIDTH'(t >> 16);
    endfunction

    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] ymag;
    logic [16:0]      y0;
    logic [16:0]      slope;
    logic [LW-1:0]    lin;

    // Odd-symmetric piecewise-linear chords through tanh at 0, .5, 1, 1.5, 2, 3.
    always_comb begin
        mag   = x[WIDTH-1] ? (~unsigned'(x) + 1'b1) : unsigned'(x);
        x0    = '0;
        y0    = 17'd0;
        slope = 17'd0;
        if (mag < HALF) begin
            x0 = '0;    y0 = 17'd0;     slope = 17'd60572;
        end else if (mag < X_1P0) begin
            x0 = HALF;  y0 = 17'd30286; slope = 17'd39252;
        end else if (mag < X_1P5) begin
            x0 = X_1P0; y0 = 17'd49912; slope = 17'd18816;
        end else if (mag < X_2P0) begin
            x0 = X_1P5; y0 = 17'd59320; slope = 17'd7716;
        end else if (mag < X_3P0) begin
            x0 = X_2P0; y0 = 17'd63178; slope = 17'd2034;
        end else begin
            x0 = X_3P0; y0 = 17'd65212; slope = 17'd0;
        end
        d    = mag - x0;
        lin  = LW'(d) * LW'(slope);
        ymag = q16_to_q(y0) + WIDTH'(lin >> 16);
        y    = x[WIDTH-1] ? signed'(~ymag + 1'b1) : signed'(ymag);
    end
endmodule

module neuron_mac_seq #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int N_IN  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*WIDTH-1:0]   a_flat,
    input  logic [N_IN*WIDTH-1:0]   w_flat,
    input  logic [WIDTH-1:0]        b,
    input  logic                    act_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        y,
    output logic                    busy
);
    localparam int PROD_W = 2 * WIDTH;
    localparam int ACC_W  = 2 * WIDTH + $clog2(N_IN + 1);
    localparam int IDX_W  = $clog2(N_IN + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(WIDTH-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;

    typedef enum logic [1:0] {IDLE, MAC, ACT, OUT} state_t;

    function automatic logic signed [WIDTH-1:0] sat_word(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [N_IN*WIDTH-1:0]    a_q, a_d;
    logic [N_IN*WIDTH-1:0]    w_q, w_d;
    logic                     act_q, act_d;
    logic [WIDTH-1:0]         y_q, y_d;
    logic                     out_valid_q, out_valid_d;

    logic signed [WIDTH-1:0]  cur_a, cur_w;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  pre;
    logic signed [WIDTH-1:0]  sat_y;
    logic signed [WIDTH-1:0]  tanh_y;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            idx_q       <= '0;
            a_q         <= '0;
            w_q         <= '0;
            act_q       <= 1'b0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            w_q         <= w_d;
            act_q       <= act_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = MAC;
            MAC:  if (idx_q == IDX_LAST) state_d = ACT;
            ACT:  state_d = OUT;
            OUT:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand mux for the single shared multiplier.
    always_comb begin
        cur_a = '0;
        cur_w = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_a = a_q[i*WIDTH +: WIDTH];
                cur_w = w_q[i*WIDTH +: WIDTH];
            end
        end
    end

    assign prod     = PROD_W'(cur_a) * PROD_W'(cur_w);
    assign bias_ext = {{(ACC_W-WIDTH){b[WIDTH-1]}}, b} <<< FRAC;
    assign pre      = acc_q >>> FRAC;
    assign sat_y    = sat_word(pre);

    neuron_tanh #(.WIDTH(WIDTH), .FRAC(FRAC)) u_tanh (
        .x (sat_y),
        .y (tanh_y)
    );

    always_comb begin
        acc_d       = acc_q;
        idx_d       = idx_q;
        a_d         = a_q;
        w_d         = w_q;
        act_d       = act_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d   = a_flat;
                w_d   = w_flat;
                act_d = act_en;
                acc_d = bias_ext;
                idx_d = '0;
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                idx_d = idx_q + 1'b1;
            end
            ACT: begin
                y_d         = act_q ? tanh_y : sat_y;
                out_valid_d = 1'b1;
            end
            OUT: if (out_ready) out_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE) && rst_n;
        busy     = (state_q != IDLE);
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: table of operand sets with expected results checked through a
// scoreboard, plus hand-written latency, backpressure, reset and back-to-back sequences.
`timescale 1ns/1ps

module tb_neuron_mac_seq;
    localparam int WIDTH = 32;
    localparam int FRAC  = 16;
    localparam int N_IN  = 4;
    localparam int NVEC  = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic act_en = 1'b0;
    logic [N_IN*WIDTH-1:0] a_flat = '0;
    logic [N_IN*WIDTH-1:0] w_flat = '0;
    logic [WIDTH-1:0] b = '0;
    logic in_ready, out_valid, busy;
    logic [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] ref_x = '0;
    logic signed [WIDTH-1:0] ref_y;

    neuron_mac_seq #(.WIDTH(WIDTH), .FRAC(FRAC), .N_IN(N_IN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_flat(a_flat), .w_flat(w_flat), .b(b), .act_en(act_en),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
    );

    neuron_tanh #(.WIDTH(WIDTH), .FRAC(FRAC)) tanh_ref (.x(ref_x), .y(ref_y));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_IN*WIDTH-1:0] a;
        logic [N_IN*WIDTH-1:0] w;
        logic [WIDTH-1:0]      b;
        logic                  act;
        logic [WIDTH-1:0]      exp_y;
        logic                  use_ref;
        logic [WIDTH-1:0]      ref_in;
    } vec_t;

    vec_t vecs [NVEC];
    logic [WIDTH-1:0] sb [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs_edge = 0;
    int last_acc_edge = 0;
    logic [WIDTH-1:0] last_y = '0;

    function automatic logic [N_IN*WIDTH-1:0] pack4(input logic [31:0] x0, input logic [31:0] x1,
                                                    input logic [31:0] x2, input logic [31:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    function automatic vec_t mk(input logic [N_IN*WIDTH-1:0] a, input logic [N_IN*WIDTH-1:0] w,
                                input logic [31:0] bb, input logic act, input logic [31:0] e,
                                input logic use_ref, input logic [31:0] ref_in);
        vec_t v;
        v.a = a; v.w = w; v.b = bb; v.act = act; v.exp_y = e; v.use_ref = use_ref; v.ref_in = ref_in;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: handshakes are decided by values stable at the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst_n && in_valid && in_ready) last_acc_edge = cyc + 1;
        if (rst_n && out_valid && out_ready) begin
            last_hs_edge = cyc + 1;
            last_y = y;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got y=0x%0h, expected no output", y);
            end else begin
                check("scoreboard_y", y, sb.pop_front());
            end
        end
    end

    task automatic load(input vec_t v);
        a_flat = v.a; w_flat = v.w; b = v.b; act_en = v.act;
    endtask

    task automatic scramble();
        a_flat = {N_IN{32'hA5A5_5A5A}};
        w_flat = {N_IN{32'h3C3C_C3C3}};
        b = 32'h1234_5678;
        act_en = ~act_en;
    endtask

    function automatic logic [WIDTH-1:0] expect_of(input vec_t v, input logic [WIDTH-1:0] ry);
        return v.use_ref ? ry : v.exp_y;
    endfunction

    task automatic send(input vec_t v);
        int k;
        k = 0;
        ref_x = v.ref_in;
        #1;
        load(v);
        in_valid = 1'b1;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%0b, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(expect_of(v, ref_y));
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk); #1; k++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: %0d results pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int first, seen, k;
        real r, got;

        vecs[0]  = mk(pack4(32'h0001_0000, 32'h0002_0000, 32'hFFFF_8000, 32'h0),
                      pack4(32'h0000_8000, 32'h0000_4000, 32'h0002_0000, 32'h0003_0000),
                      32'h0000_4000, 1'b0, 32'h0000_4000, 1'b0, 32'h0);
        vecs[1]  = mk({N_IN{32'h7FFF_0000}}, {N_IN{32'h7FFF_0000}}, 32'h7FFF_FFFF, 1'b0,
                      32'h7FFF_FFFF, 1'b0, 32'h0);
        vecs[2]  = mk({N_IN{32'h8000_0000}}, {N_IN{32'h7FFF_0000}}, 32'h0, 1'b0,
                      32'h8000_0000, 1'b0, 32'h0);
        vecs[3]  = mk('0, {N_IN{32'h0001_0000}}, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
        vecs[4]  = mk(pack4(32'h0001_0000, 32'h0, 32'h0, 32'h0), pack4(32'h0001_0000, 32'h0, 32'h0, 32'h0),
                      32'h0, 1'b1, 32'h0, 1'b1, 32'h0001_0000);
        vecs[5]  = mk(pack4(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0), pack4(32'h1, 32'h0, 32'h0, 32'h0),
                      32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0);
        vecs[6]  = mk(pack4(32'h1, 32'h0, 32'h0, 32'h0), pack4(32'h0000_8000, 32'h0, 32'h0, 32'h0),
                      32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        vecs[7]  = mk('0, '0, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b0, 32'h0);
        vecs[8]  = mk('0, '0, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 32'h0);
        vecs[9]  = mk(pack4(32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0), pack4(32'h0001_0000, 32'h0, 32'h0, 32'h0),
                      32'h1, 1'b0, 32'h7FFF_FFFF, 1'b0, 32'h0);
        vecs[10] = mk({N_IN{32'h8000_0000}}, {N_IN{32'h8000_0000}}, 32'h0, 1'b0,
                      32'h7FFF_FFFF, 1'b0, 32'h0);
        vecs[11] = mk(pack4(32'h0003_0000, 32'hFFFE_8000, 32'h0000_C000, 32'hFFFE_0000),
                      pack4(32'hFFFF_0000, 32'h0002_0000, 32'h0004_0000, 32'hFFFF_C000),
                      32'hFFFF_0000, 1'b0, 32'hFFFC_8000, 1'b0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_y", y, 0);

        load(vecs[0]);
        in_valid = 1'b1;
        sb.push_back(32'h0000_4000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        check("busy_after_accept", busy, 1);
        first = 0;
        for (int e = 1; e <= N_IN + 3; e++) begin
            @(posedge clk); #1;
            if (out_valid && first == 0) first = e;
        end
        check("latency_edges", first, N_IN + 1);
        wait_drain("latency");

        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i]);
            wait_drain("table");
            if (vecs[i].use_ref) begin
                r = $tanh($itor($signed(vecs[i].ref_in)) / 65536.0);
                got = $itor($signed(last_y)) / 65536.0;
                checks++;
                if (got - r > 0.02 || r - got > 0.02) begin
                    errors++;
                    $display("FAIL tanh_accuracy: got %f, expected %f within 0.02", got, r);
                end
            end
        end

        out_ready = 1'b0;
        send(vecs[11]);
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk); #1; k++;
        end
        check("bp_valid_rise", out_valid, 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_y_stable", y, 32'hFFFC_8000);
            check("bp_valid_held", out_valid, 1);
            check("bp_in_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", out_valid, 0);
        check("bp_in_ready_rise", in_ready, 1);
        wait_drain("bp");

        send(vecs[1]);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_y", y, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midrst_no_output", seen, 0);
        send(vecs[0]);
        wait_drain("after_reset");
        check("after_reset_y", last_y, 32'h0000_4000);

        load(vecs[5]);
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        sb.push_back(32'hFFFF_FFFF);
        @(posedge clk); #1;
        load(vecs[6]);
        sb.push_back(32'h0);
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        check("b2b_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_accept_gap", last_acc_edge, last_hs_edge + 1);
        wait_drain("b2b");
        check("b2b_second_y", last_y, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
